mcu_spi_target: RTL
===================

MCU_SPI_TARGET -- requirements
Module: mcu_spi_target

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have a parameter TIMEOUT_CYCLES, default 16'd65535, giving the idle SCLK cycles before a byte abort (used only with MCU_SPI_TIMEOUT_EN).
REQ-003 SHALL have the port clk  in  1  system clock; all logic is in this domain.
REQ-004 SHALL have the port reset  in  1  async active-high reset.
REQ-005 SHALL have the port spi_csn  in  1  MCU chip select, active low, asynchronous.
REQ-006 SHALL have the port spi_sclk  in  1  MCU SPI clock, mode 0, asynchronous.
REQ-007 SHALL have the port spi_mosi  in  1  MCU data in, MSB first.
REQ-008 SHALL have the port spi_miso  out  1  data to MCU, MSB first.
REQ-009 SHALL have the port data_in_strobe  out  1  one-clk pulse per completed byte, fed to the system control block.
REQ-010 SHALL have the port data_in_start  out  1  high with data_in_strobe on the first byte of a frame.
REQ-011 SHALL have the port data_in  out  8  received byte.
REQ-012 SHALL have the port data_out  in  8  reply byte from the system control block.
REQ-013 SHALL have the port busy  out  1  frame in progress.
REQ-014 SHALL have the port frame_err  out  1  one-clk pulse on an aborted or partial byte.

Function
REQ-015 SHALL pass spi_csn, spi_sclk and spi_mosi each through a 2-flop synchronizer, plus one delay flop on sclk and csn for edge detection.
REQ-016 SHALL use states IDLE (csn high), FIRST (awaiting the first byte), BODY (later bytes) and ABORT (timed out, csn still low).
REQ-017 SHALL move IDLE->FIRST on a synchronized csn falling edge, clearing bit_cnt, tx_reg<=8'h00 and busy<=1.
REQ-018 SHALL, on a synchronized sclk rising edge in FIRST or BODY, shift synchronized mosi into rx_reg[0] and increment the 3-bit bit_cnt, wrapping 7->0.
REQ-019 SHALL, on the rising edge that wraps bit_cnt to 0, update data_in from the full byte and assert data_in_strobe in the next clk for exactly one cycle.
REQ-020 SHALL assert data_in_start with that strobe only when the state is FIRST, then move FIRST->BODY.
REQ-021 SHALL hold data_in stable until the next strobe.
REQ-022 SHALL load tx_reg<=data_out one clk after each data_in_strobe, because the reply lags the request by one byte.
REQ-023 SHALL drive spi_miso = tx_reg[7] while csn is low, and 0 while csn is high.
REQ-024 SHALL, on a synchronized sclk falling edge with bit_cnt in 1..7, shift tx_reg left by one.
REQ-025 SHALL ignore a falling edge with bit_cnt==0.
REQ-026 SHALL, on a synchronized csn rising edge in any state, go to IDLE with busy<=0.
REQ-027 SHALL, if bit_cnt!=0 at that csn rise, pulse frame_err for one clk and emit no strobe.
REQ-028 SHALL, when a csn rise and an sclk edge are detected in the same clk, let the csn rise win and ignore the edge.
REQ-029 SHALL discard sclk edges while in IDLE.
REQ-030 SHALL hold data_in_strobe and data_in_start low in every state other than FIRST and BODY.
REQ-031 SHALL guarantee correct operation for SCLK high and low times of at least 4 clk cycles each.

Reset
REQ-032 SHALL, while reset is asserted, force state=IDLE, bit_cnt=0, rx_reg=0, tx_reg=0, data_in=8'h00, data_in_strobe=0, data_in_start=0, busy=0, frame_err=0, spi_miso=0, all synchronizer flops to 1 (csn/sclk) and 0 (mosi).
REQ-033 SHALL discard a frame interrupted by reset mid-byte with no strobe, and SHALL restart it only on a fresh csn falling edge.

Configuration
REQ-034 SHALL, with MCU_SPI_TIMEOUT_EN defined, use a 16-bit counter that clears on every sclk edge and counts while state is FIRST or BODY with bit_cnt!=0.
REQ-035 SHALL, when that counter reaches TIMEOUT_CYCLES, pulse frame_err once, clear bit_cnt, drive spi_miso=0 and enter ABORT, staying there until csn rises.
REQ-036 SHALL, without MCU_SPI_TIMEOUT_EN, leave out the counter and ABORT, with no timeout behaviour and a partial byte held indefinitely.

Verification
REQ-037 SHALL cover: csn low, MOSI 8'h00 then 8'h5A, data_out=8'hC3 held -> two strobes, first with start=1 and data_in=8'h00, second with start=0 and data_in=8'h5A; MISO byte 2 = 8'hC3.
REQ-038 SHALL cover: a 3-byte frame 8'h07,8'h01,8'h02 with data_out changing 8'h11->8'h22 after each strobe -> MISO bytes 8'h00,8'h11,8'h22.
REQ-039 SHALL cover: csn rise after 5 bits of byte 2 -> exactly one strobe, one frame_err pulse, state IDLE, busy=0, spi_miso=0.
REQ-040 SHALL cover: reset asserted after bit 4, then released, then a new frame with 8'hA5 -> all outputs zero during reset, no strobe for the partial byte, next strobe has start=1 and data_in=8'hA5.
REQ-041 SHALL cover, with MCU_SPI_TIMEOUT_EN and TIMEOUT_CYCLES=100: SCLK stops after bit 3 -> frame_err at idle clk 100, later sclk edges ignored until csn rises, and the next frame works normally.
REQ-042 SHALL cover: back-to-back frames with csn high for 4 clk -> the second frame's first strobe carries start=1.

Source files
------------

// File: rtl/mcu_spi_target_if.sv
// Bundle of the MCU-facing SPI pins and the byte-wide handshake to the system control block.
// slave is the target's view; master is the view of whatever drives the SPI pins and data_out.
interface mcu_spi_target_if;
  logic       spi_csn;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy;
  logic       frame_err;

  modport slave (
    input  spi_csn, spi_sclk, spi_mosi, data_out,
    output spi_miso, data_in_strobe, data_in_start, data_in, busy, frame_err
  );

  modport master (
    output spi_csn, spi_sclk, spi_mosi, data_out,
    input  spi_miso, data_in_strobe, data_in_start, data_in, busy, frame_err
  );
endinterface

// File: rtl/mcu_spi_target.sv
// Mode-0 SPI target oversampled in the clk domain; delivers one strobe per received byte.
// Optional idle-SCLK byte abort is enabled by defining MCU_SPI_TIMEOUT_EN.
module mcu_spi_target #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic              clk,
  input  logic              reset,
  mcu_spi_target_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    BODY  = 2'd2
`ifdef MCU_SPI_TIMEOUT_EN
    , ABORT = 2'd3
`endif
  } state_e;

  logic       csn_s1_q, csn_s2_q, csn_dly_q;
  logic       sclk_s1_q, sclk_s2_q, sclk_dly_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [1:0] settle_q;
  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_q, tx_q, data_in_q;
  logic       strobe_q, start_q, busy_q, frame_err_q;

  logic       csn_fall, csn_rise, sclk_rise, sclk_fall;
  logic       in_frame;
  logic [7:0] rx_d;

  // A csn already low at reset release looks like a falling edge until the
  // synchronizer has filled with real pin samples, so that edge is masked.
  assign csn_fall  = csn_dly_q & ~csn_s2_q & (settle_q == 2'd3);
  assign csn_rise  = ~csn_dly_q & csn_s2_q;
  assign sclk_rise = ~sclk_dly_q & sclk_s2_q;
  assign sclk_fall = sclk_dly_q & ~sclk_s2_q;
  assign in_frame  = (state_q == FIRST) || (state_q == BODY);
  assign rx_d      = {rx_q[6:0], mosi_s2_q};

`ifdef MCU_SPI_TIMEOUT_EN
  logic [15:0] idle_cnt_q;
  logic        timeout;

  assign timeout = in_frame && (bit_cnt_q != 3'd0) && (idle_cnt_q == TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= 16'd0;
    end else if (sclk_rise || sclk_fall) begin
      idle_cnt_q <= 16'd0;
    end else if (in_frame && (bit_cnt_q != 3'd0)) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end else begin
      idle_cnt_q <= 16'd0;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT_CYCLES;
`endif

  // NOTE: every register here is assigned with <= so all flops sample the
  // same pre-edge values; blocking assignments would collapse the synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: csn/sclk synchronizers reset to the idle-high level so no
      // spurious edge is seen as reset releases; mosi idles low.
      csn_s1_q    <= 1'b1;
      csn_s2_q    <= 1'b1;
      csn_dly_q   <= 1'b1;
      sclk_s1_q   <= 1'b1;
      sclk_s2_q   <= 1'b1;
      sclk_dly_q  <= 1'b1;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      settle_q    <= 2'd0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      data_in_q   <= 8'h00;
      strobe_q    <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      csn_s1_q   <= bus.spi_csn;
      csn_s2_q   <= csn_s1_q;
      csn_dly_q  <= csn_s2_q;
      sclk_s1_q  <= bus.spi_sclk;
      sclk_s2_q  <= sclk_s1_q;
      sclk_dly_q <= sclk_s2_q;
      mosi_s1_q  <= bus.spi_mosi;
      mosi_s2_q  <= mosi_s1_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;

      strobe_q    <= 1'b0;
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (csn_fall) begin
            state_q   <= FIRST;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            busy_q    <= 1'b1;
          end
        end

        FIRST, BODY: begin
          // csn rise outranks any sclk edge seen in the same clk.
          if (csn_rise) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            tx_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            frame_err_q <= (bit_cnt_q != 3'd0);
          end
`ifdef MCU_SPI_TIMEOUT_EN
          else if (timeout) begin
            state_q     <= ABORT;
            bit_cnt_q   <= 3'd0;
            tx_q        <= 8'h00;
            frame_err_q <= 1'b1;
          end
`endif
          else if (sclk_rise) begin
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_in_q <= rx_d;
              strobe_q  <= 1'b1;
              start_q   <= (state_q == FIRST);
              state_q   <= BODY;
            end
          end else if (strobe_q) begin
            // Reply for this byte goes out during the next one.
            tx_q <= bus.data_out;
          end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
            tx_q <= {tx_q[6:0], 1'b0};
          end
        end

`ifdef MCU_SPI_TIMEOUT_EN
        ABORT: begin
          if (csn_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.spi_miso       = ~csn_s2_q & tx_q[7];
  assign bus.data_in_strobe = strobe_q;
  assign bus.data_in_start  = start_q;
  assign bus.data_in        = data_in_q;
  assign bus.busy           = busy_q;
  assign bus.frame_err      = frame_err_q;

endmodule
